// File: rtl/adder_feed_serializer.sv
// adder_feed_serializer
//   Upstream feeder for the three-operand sequential adder. Operand triples
//   arrive in parallel over a valid/ready handshake, are buffered in a small
//   FIFO and replayed as a single-word stream: irdy with a on din, then b and c
//   on the next two cycles. Triples are spaced so the adder always sits in its
//   input-wait state when irdy rises.
//
//   Optional build macro ADDER_FEED_ORDY_CHECK_EN: when defined, a new triple
//   only starts once adder_ordy is high (except the very first triple after
//   reset), and back-to-back triples pass through IDLE so the check applies.
module adder_feed_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             in_ready,
  output logic [WIDTH-1:0] din,
  output logic             irdy,
  input  logic             adder_ordy,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S0   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  logic [3*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [AW:0]        count_nxt;
  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [3:0]         gap_cnt;
  logic [3:0]         gap_nxt;
  logic               ready_en;
  logic               push;
  logic               pop;
  logic               start_ok;
  logic [3*WIDTH-1:0] head;

  assign push     = in_valid && in_ready;
  assign pop      = (state == S2);
  assign in_ready = ready_en && (count != FULL_CNT);
  assign busy     = (count != '0) || (state != IDLE);
  assign head     = mem[rd_ptr];

`ifdef ADDER_FEED_ORDY_CHECK_EN
  logic first_pending;

  // Remembers that no triple has been issued since reset, so the first one
  // does not wait for an adder result flag that can never come.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      first_pending <= 1'b1;
    else if (state == S0)
      first_pending <= 1'b0;
  end

  assign start_ok = adder_ordy || first_pending;
`else
  logic unused_adder_ordy;

  assign unused_adder_ordy = adder_ordy;
  assign start_ok          = 1'b1;
`endif

  // in_ready stays low through reset and opens on the first edge after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ready_en <= 1'b0;
    else
      ready_en <= 1'b1;
  end

  // FIFO storage: a whole triple is written as one entry at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_c};
    end
  end

  // Occupancy after this cycle's push/pop; also steers the S2 exit.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Sequencer: walk a, b, c of the head entry, then optionally idle GAP cycles.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if ((count != '0) && start_ok)
          state_nxt = S0;
      end
      S0: state_nxt = S1;
      S1: state_nxt = S2;
      S2: begin
        if (GAP > 0) begin
          state_nxt = WAIT;
          gap_nxt   = GAP_LOAD;
        end else begin
`ifdef ADDER_FEED_ORDY_CHECK_EN
          state_nxt = IDLE;
`else
          state_nxt = (count_nxt != '0) ? S0 : IDLE;
`endif
        end
      end
      WAIT: begin
        if (gap_cnt == 4'd0)
          state_nxt = ((count != '0) && start_ok) ? S0 : IDLE;
        else
          gap_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Moore output decode from the state and the FIFO head.
  always_comb begin
    irdy = 1'b0;
    din  = '0;
    case (state)
      S0: begin
        irdy = 1'b1;
        din  = head[3*WIDTH-1 -: WIDTH];
      end
      S1:      din = head[2*WIDTH-1 -: WIDTH];
      S2:      din = head[WIDTH-1:0];
      default: din = '0;
    endcase
  end

endmodule

// File: tb/tb_adder_feed_serializer.sv
// Directed bench for adder_feed_serializer: one GAP=0 instance and one GAP=2
// instance sharing clock and reset. A per-cycle monitor follows each strobe
// through a, b, c against the pushed triples.
module tb_adder_feed_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        adder_ordy;

  logic        in_valid, in_ready, irdy, busy;
  logic [15:0] in_a, in_b, in_c, din;
  logic        g_in_valid, g_in_ready, g_irdy, g_busy;
  logic [15:0] g_in_a, g_in_b, g_in_c, g_din;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] qa [16];
  logic [15:0] qb [16];
  logic [15:0] qc [16];
  int          nq, push_idx, mon_idx, ph, cyc_no, held;
  int          pulses [$];
  logic [15:0] sum_acc;

  always #5 clk = ~clk;

  adder_feed_serializer #(.WIDTH(16), .DEPTH(4), .GAP(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_ready(in_ready), .din(din), .irdy(irdy),
    .adder_ordy(adder_ordy), .busy(busy)
  );

  adder_feed_serializer #(.WIDTH(16), .DEPTH(4), .GAP(2)) dut_gap (
    .clk(clk), .reset(reset), .in_valid(g_in_valid), .in_a(g_in_a), .in_b(g_in_b),
    .in_c(g_in_c), .in_ready(g_in_ready), .din(g_din), .irdy(g_irdy),
    .adder_ordy(adder_ordy), .busy(g_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    nq       = 0;
    push_idx = 0;
    mon_idx  = 0;
    ph       = 0;
    cyc_no   = 0;
    held     = 0;
    pulses.delete();
  endtask

  task automatic add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    qa[nq] = a;
    qb[nq] = b;
    qc[nq] = c;
    nq++;
  endtask

  task automatic monitor(input bit sel);
    logic        oi;
    logic [15:0] od;
    logic [15:0] es;
    oi = sel ? g_irdy : irdy;
    od = sel ? g_din : din;
    case (ph)
      0: begin
        if (oi) begin
          if (mon_idx < nq) begin
            chk("din_a", od, qa[mon_idx]);
            pulses.push_back(cyc_no);
            sum_acc = od;
            ph = 1;
          end else begin
            chk("spurious_irdy", oi, 0);
          end
        end else begin
          chk("idle_din", od, 0);
        end
      end
      1: begin
        chk("irdy_b", oi, 0);
        chk("din_b", od, qb[mon_idx]);
        sum_acc = sum_acc + od;
        ph = 2;
      end
      default: begin
        chk("irdy_c", oi, 0);
        chk("din_c", od, qc[mon_idx]);
        sum_acc = sum_acc + od;
        es = qa[mon_idx] + qb[mon_idx] + qc[mon_idx];
        chk("sum", sum_acc, es);
        mon_idx++;
        ph = 0;
      end
    endcase
  endtask

  task automatic cyc(input bit sel, input bit allow);
    bit   pres;
    logic rdy;
    pres = allow && (push_idx < nq);
    rdy  = sel ? g_in_ready : in_ready;
    if (sel) begin
      g_in_valid = pres;
      if (pres) begin
        g_in_a = qa[push_idx]; g_in_b = qb[push_idx]; g_in_c = qc[push_idx];
      end
    end else begin
      in_valid = pres;
      if (pres) begin
        in_a = qa[push_idx]; in_b = qb[push_idx]; in_c = qc[push_idx];
      end
    end
    step();
    if (pres && rdy)  push_idx++;
    if (pres && !rdy) held++;
    monitor(sel);
    cyc_no++;
  endtask

  initial begin
    reset      = 1'b1;
    adder_ordy = 1'b1;
    in_valid   = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    g_in_valid = 1'b0; g_in_a = '0; g_in_b = '0; g_in_c = '0;
    begin_test();

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_gap_in_ready", g_in_ready, 0);
    chk("rst_irdy", irdy, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("rdy_before_edge", in_ready, 0);
    step();
    chk("rdy_after_edge", in_ready, 1);

    // Single triple
    begin_test();
    add(16'h0001, 16'h0002, 16'h0003);
    repeat (8) cyc(0, 1);
    chk("single_pulses", pulses.size(), 1);
    chk("single_latency", pulses[0], 1);
    chk("single_done", mon_idx, 1);
    chk("single_busy", busy, 0);

    // Back-to-back, GAP = 0: strobes 3 cycles apart, sums 3, 6, 0
    begin_test();
    add(16'h0001, 16'h0001, 16'h0001);
    add(16'h0002, 16'h0002, 16'h0002);
    add(16'hFFFF, 16'h0001, 16'h0000);
    repeat (14) cyc(0, 1);
    chk("b2b_pulses", pulses.size(), 3);
    chk("b2b_t0", pulses[0], 1);
    chk("b2b_t1", pulses[1], 4);
    chk("b2b_t2", pulses[2], 7);
    chk("b2b_busy", busy, 0);

    // GAP = 2: strobes 5 cycles apart, din 0 in the wait cycles
    begin_test();
    add(16'h0010, 16'h0020, 16'h0030);
    add(16'h0040, 16'h0050, 16'h0060);
    repeat (14) cyc(1, 1);
    chk("gap_pulses", pulses.size(), 2);
    chk("gap_t0", pulses[0], 1);
    chk("gap_t1", pulses[1], 6);
    chk("gap_busy", g_busy, 0);

    // Full FIFO: continuous offer of 8 triples, 4 buffered plus one in flight
    begin_test();
    for (int i = 0; i < 8; i++)
      add(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i));
    repeat (6) cyc(0, 1);
    chk("full_accepted", push_idx, 5);
    chk("full_in_ready", in_ready, 0);
    chk("full_held", held, 1);
    repeat (40) cyc(0, 1);
    chk("full_all_out", mon_idx, 8);
    chk("full_all_in", push_idx, 8);
    chk("full_busy", busy, 0);

    // Pointer wrap with random in_valid gaps
    begin_test();
    for (int i = 0; i < 9; i++)
      add(16'(i) * 16'h1111, 16'hA000 + 16'(i), 16'h0F00 - 16'(i));
    for (int i = 0; i < 80; i++)
      cyc(0, (i >= 40) || ($urandom_range(0, 1) == 1));
    chk("wrap_all_in", push_idx, 9);
    chk("wrap_all_out", mon_idx, 9);
    chk("wrap_busy", busy, 0);

    // Reset in S1 with more triples queued
    begin_test();
    add(16'h1111, 16'h2222, 16'h3333);
    add(16'h4444, 16'h5555, 16'h6666);
    add(16'h7777, 16'h8888, 16'h9999);
    repeat (3) cyc(0, 1);
    chk("mid_in_s1", din, 16'h2222);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_irdy", irdy, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    chk("mid_rst_in_ready_edge", in_ready, 0);
    reset = 1'b0;
    step();
    chk("mid_post_busy", busy, 0);
    chk("mid_post_in_ready", in_ready, 1);
    begin_test();
    repeat (6) cyc(0, 0);
    chk("mid_no_pulse", pulses.size(), 0);
    chk("mid_still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
